// File: rtl/mult_wb_buffer_pkg.sv
// rtl/mult_wb_buffer_pkg.sv - shared multiplier latency, tag widths and writeback packet type
package mult_wb_buffer_pkg;

    localparam int MULT_LATENCY = 5;
    localparam int PRD_W        = 6;
    localparam int ROB_W        = 5;

    typedef struct packed {
        logic [31:0]      data;
        logic [PRD_W-1:0] prd;
        logic [ROB_W-1:0] rob;
    } mult_wb_packet_t;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// rtl/mult_tag_pipe.sv - fixed-latency {valid, prd, rob} shift chain with in-flight popcount
module mult_tag_pipe
    import mult_wb_buffer_pkg::*;
#(
    parameter int LATENCY = mult_wb_buffer_pkg::MULT_LATENCY,
    parameter int PRD_W   = mult_wb_buffer_pkg::PRD_W,
    parameter int ROB_W   = mult_wb_buffer_pkg::ROB_W,
    parameter int CNT_W   = cnt_width(LATENCY)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PRD_W-1:0] in_prd,
    input  logic [ROB_W-1:0] in_rob,
    output logic             last_valid,
    output logic [PRD_W-1:0] last_prd,
    output logic [ROB_W-1:0] last_rob,
    output logic [CNT_W-1:0] inflight
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [PRD_W-1:0]   prd_q [LATENCY];
    logic [PRD_W-1:0]   prd_d [LATENCY];
    logic [ROB_W-1:0]   rob_q [LATENCY];
    logic [ROB_W-1:0]   rob_d [LATENCY];

    // The multiplier never stalls, so the chain advances every cycle.
    always_comb begin
        valid_d[0] = in_valid;
        prd_d[0]   = in_prd;
        rob_d[0]   = in_rob;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            prd_d[i]   = prd_q[i-1];
            rob_d[i]   = rob_q[i-1];
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                prd_q[i] <= '0;
                rob_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                prd_q[i] <= prd_d[i];
                rob_q[i] <= rob_d[i];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CNT_W'(valid_q[i]);
        end
    end

    assign last_valid = valid_q[LATENCY-1];
    assign last_prd   = prd_q[LATENCY-1];
    assign last_rob   = rob_q[LATENCY-1];

endmodule

// File: rtl/mult_wb_buffer.sv
// rtl/mult_wb_buffer.sv - tags multiplier results and queues them for writeback with issue credits; MULT_WB_BYPASS_EN adds empty-FIFO bypass
module mult_wb_buffer
    import mult_wb_buffer_pkg::*;
#(
    parameter int MULT_LATENCY = mult_wb_buffer_pkg::MULT_LATENCY,
    parameter int DEPTH        = 4,
    parameter int PRD_W        = mult_wb_buffer_pkg::PRD_W,
    parameter int ROB_W        = mult_wb_buffer_pkg::ROB_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [PRD_W-1:0] issue_prd,
    input  logic [ROB_W-1:0] issue_rob,
    output logic             issue_ready,
    input  logic [31:0]      mult_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [PRD_W-1:0] wb_prd,
    output logic [ROB_W-1:0] wb_rob
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int INF_W = cnt_width(MULT_LATENCY);
    localparam int CRD_W = cnt_width(DEPTH + MULT_LATENCY);

    typedef struct packed {
        logic [31:0]      data;
        logic [PRD_W-1:0] prd;
        logic [ROB_W-1:0] rob;
    } pkt_t;

    pkt_t             mem_q [DEPTH];
    pkt_t             mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             last_valid;
    logic [PRD_W-1:0] last_prd;
    logic [ROB_W-1:0] last_rob;
    logic [INF_W-1:0] inflight;

    logic             fifo_valid;
    logic             bypass_hit;
    logic             push;
    logic             pop;
    pkt_t             head_pkt;

    // Credit counts every tag in flight as an occupied slot, so arrivals can never overflow.
    assign issue_ready = (CRD_W'(inflight) + CRD_W'(count_q)) < CRD_W'(DEPTH);

    mult_tag_pipe #(
        .LATENCY (MULT_LATENCY),
        .PRD_W   (PRD_W),
        .ROB_W   (ROB_W),
        .CNT_W   (INF_W)
    ) u_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (issue_valid & issue_ready),
        .in_prd     (issue_prd),
        .in_rob     (issue_rob),
        .last_valid (last_valid),
        .last_prd   (last_prd),
        .last_rob   (last_rob),
        .inflight   (inflight)
    );

    always_comb begin
        fifo_valid = (count_q != '0);
`ifdef MULT_WB_BYPASS_EN
        bypass_hit = !fifo_valid && last_valid;
`else
        bypass_hit = 1'b0;
`endif
        head_pkt = mem_q[head_q];
        wb_valid = fifo_valid | bypass_hit;
        wb_data  = '0;
        wb_prd   = '0;
        wb_rob   = '0;
        if (fifo_valid) begin
            wb_data = head_pkt.data;
            wb_prd  = head_pkt.prd;
            wb_rob  = head_pkt.rob;
        end else if (bypass_hit) begin
            wb_data = mult_out;
            wb_prd  = last_prd;
            wb_rob  = last_rob;
        end
        pop  = fifo_valid & wb_ready;
        // A bypassed result taken by the arbiter never occupies a slot.
        push = last_valid & !(bypass_hit & wb_ready);
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[tail_q] = '{data: mult_out, prd: last_prd, rob: last_rob};
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_mult_wb_buffer.sv
// tb/tb_mult_wb_buffer.sv - randomized scoreboard bench for mult_wb_buffer
module tb_mult_wb_buffer;
    import mult_wb_buffer_pkg::*;

    localparam int L     = MULT_LATENCY;
    localparam int DEPTH = 4;
`ifdef MULT_WB_BYPASS_EN
    localparam int VIS_OFF = 0;
`else
    localparam int VIS_OFF = 1;
`endif

    logic             clock;
    logic             reset;
    logic             flush;
    logic             issue_valid;
    logic [PRD_W-1:0] issue_prd;
    logic [ROB_W-1:0] issue_rob;
    logic             issue_ready;
    logic [31:0]      mult_out;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [PRD_W-1:0] wb_prd;
    logic [ROB_W-1:0] wb_rob;

    mult_wb_buffer #(
        .MULT_LATENCY (L),
        .DEPTH        (DEPTH),
        .PRD_W        (PRD_W),
        .ROB_W        (ROB_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_prd   (issue_prd),
        .issue_rob   (issue_rob),
        .issue_ready (issue_ready),
        .mult_out    (mult_out),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_prd      (wb_prd),
        .wb_rob      (wb_rob)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int              issue_cyc;
        mult_wb_packet_t pkt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        popped;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] issue_data;
    bit          exp_ready;
    bit          exp_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: every accepted op is one outstanding packet until popped; it becomes visible
    // a fixed number of cycles after issue, and credit exists while fewer than DEPTH are outstanding.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            check("wb_valid_in_reset", wb_valid, 0);
        end else begin
            exp_ready = exp_q.size() < DEPTH;
            exp_valid = exp_q.size() > 0 && (exp_q[0].issue_cyc + L + VIS_OFF <= cyc);
            check("issue_ready", issue_ready, exp_ready);
            check("wb_valid", wb_valid, exp_valid);
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_packet: got data %0h prd %0h rob %0h expected none (cycle %0d)",
                             wb_data, wb_prd, wb_rob, cyc);
                end else begin
                    popped = exp_q.pop_front();
                    check("wb_data", wb_data, popped.pkt.data);
                    check("wb_prd", wb_prd, popped.pkt.prd);
                    check("wb_rob", wb_rob, popped.pkt.rob);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (issue_valid && exp_ready) begin
                exp_q.push_back('{issue_cyc: cyc,
                                  pkt: '{data: issue_data, prd: issue_prd, rob: issue_rob}});
            end
        end
        cyc++;
    end

    // Plays the multiplier: the op issued L cycles ago gets its chosen result, anything else is noise.
    task automatic drive(input bit iv, input logic [PRD_W-1:0] p, input logic [ROB_W-1:0] r,
                         input logic [31:0] d, input bit rdy, input bit fl);
        @(posedge clock);
        #1;
        issue_valid = iv;
        issue_prd   = p;
        issue_rob   = r;
        issue_data  = d;
        wb_ready    = rdy;
        flush       = fl;
        mult_out    = $urandom();
        foreach (exp_q[i]) begin
            if (exp_q[i].issue_cyc + L == cyc) mult_out = exp_q[i].pkt.data;
        end
    endtask

    task automatic issue_rand(input bit rdy);
        drive(1'b1, PRD_W'($urandom()), ROB_W'($urandom()), $urandom(), rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, PRD_W'($urandom()), ROB_W'($urandom()), $urandom(), rdy, 1'b0);
    endtask

    logic [31:0] b2b_data [4];

    initial begin
        b2b_data[0] = 32'd110;
        b2b_data[1] = 32'd11100;
        b2b_data[2] = 32'd1111000;
        b2b_data[3] = 32'd111110000;
        reset       = 1'b1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_prd   = '0;
        issue_rob   = '0;
        issue_data  = '0;
        mult_out    = '0;
        wb_ready    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_wb_valid", wb_valid, 0);
        check("reset_wb_data", wb_data, 0);
        check("reset_wb_prd", wb_prd, 0);
        check("reset_wb_rob", wb_rob, 0);
        reset = 1'b0;
        #1;
        check("issue_ready_after_reset", issue_ready, 1);

        // single op
        drive(1'b1, PRD_W'(7), ROB_W'(3), 32'd110, 1'b1, 1'b0);
        repeat (8) idle(1'b1);

        // back-to-back, count==1 push/pop overlap
        foreach (b2b_data[i]) drive(1'b1, PRD_W'($urandom()), ROB_W'($urandom()), b2b_data[i], 1'b1, 1'b0);
        repeat (10) idle(1'b1);

        // backpressure: credits run out after DEPTH accepted issues
        repeat (8) issue_rand(1'b0);
        repeat (6) idle(1'b0);
        repeat (10) idle(1'b1);

        // flush with one buffered and two in flight
        issue_rand(1'b0);
        repeat (2) idle(1'b0);
        repeat (2) issue_rand(1'b0);
        idle(1'b0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        repeat (10) idle(1'b1);

        // async reset mid-cycle with one buffered and three in flight
        repeat (4) issue_rand(1'b0);
        repeat (2) idle(1'b0);
        idle(1'b0);
        #2;
        check("wb_valid_before_reset", wb_valid, 1);
        reset = 1'b1;
        #1;
        check("wb_valid_async_reset", wb_valid, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (12) idle(1'b1);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 6, PRD_W'($urandom()), ROB_W'($urandom()), $urandom(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        repeat (20) idle(1'b1);
        @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
